el2_dcls_comparator: RTL and testbench



---
 rtl/el2_pkg.sv | 20 ++
 rtl/el2_dcls_comparator_if.sv | 42 ++++
 rtl/el2_dcls_delay_line.sv | 32 +++
 rtl/el2_dcls_comparator.sv | 169 ++++++++++++++++
 tb/tb_el2_dcls_comparator.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/el2_pkg.sv
// Shared types and legal parameter ranges for the EL2 dual-core
// lockstep comparator.
package el2_pkg;

   localparam int NUM_CH_MIN = 1;
   localparam int NUM_CH_MAX = 8;
   localparam int DELAY_MIN  = 0;
   localparam int DELAY_MAX  = 4;

   typedef enum logic [1:0] {
      DISABLED = 2'd0,
      MONITOR  = 2'd1,
      FAULT    = 2'd2
   } dcls_state_e;

   function automatic int first_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/el2_dcls_comparator_if.sv
// Main/shadow observation bus plus status outputs of the lockstep
// comparator.
interface el2_dcls_comparator_if #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 32,
   parameter int CNT_W  = 8
) ();
   localparam int FW = el2_pkg::first_w(NUM_CH);

   logic [NUM_CH*CH_W-1:0] main_data_i;
   logic [NUM_CH-1:0]      main_valid_i;
   logic [NUM_CH*CH_W-1:0] shadow_data_i;
   logic [NUM_CH-1:0]      shadow_valid_i;
   logic [NUM_CH-1:0]      ch_mask_i;
   logic                   disable_detection_i;
   logic                   err_inj_en_i;
   logic                   clear_i;
   logic                   corruption_detected_o;
   logic [NUM_CH-1:0]      mismatch_ch_o;
   logic [CNT_W-1:0]       mismatch_cnt_o;
   logic [FW-1:0]          first_ch_o;
   logic [1:0]             state_o;

   modport master (
      output main_data_i, main_valid_i,
      output shadow_data_i, shadow_valid_i,
      output ch_mask_i, disable_detection_i,
      output err_inj_en_i, clear_i,
      input  corruption_detected_o, mismatch_ch_o,
      input  mismatch_cnt_o, first_ch_o, state_o
   );

   modport slave (
      input  main_data_i, main_valid_i,
      input  shadow_data_i, shadow_valid_i,
      input  ch_mask_i, disable_detection_i,
      input  err_inj_en_i, clear_i,
      output corruption_detected_o, mismatch_ch_o,
      output mismatch_cnt_o, first_ch_o, state_o
   );

endinterface

// File: rtl/el2_dcls_delay_line.sv
// Free-running register pipeline that aligns main-core outputs with
// the lagging shadow core; depth 0 is a plain wire.
module el2_dcls_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o
);

   if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign dout_o = din_i;
   end else begin : g_pipe
      logic [WIDTH-1:0] pipe_q [DEPTH];

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
         end else begin
            pipe_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
         end
      end

      assign dout_o = pipe_q[DEPTH-1];
   end

endmodule

// File: rtl/el2_dcls_comparator.sv
// Dual-core lockstep comparator: delays main outputs, compares them
// against the shadow core and keeps sticky fault status.
module el2_dcls_comparator
   import el2_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 32,
   parameter int DELAY  = 2,
   parameter int CNT_W  = 8
) (
   input logic                  clk,
   input logic                  rst,
   el2_dcls_comparator_if.slave bus
);

   localparam int DW = NUM_CH * CH_W;
   localparam int PW = DW + NUM_CH;
   localparam int FW = first_w(NUM_CH);

   logic [PW-1:0]     pipe_in;
   logic [PW-1:0]     pipe_out;
   logic [DW-1:0]     m_data;
   logic [DW-1:0]     s_cmp;
   logic [NUM_CH-1:0] m_valid;
   logic [NUM_CH-1:0] both;
   logic [NUM_CH-1:0] mm;
   logic [FW-1:0]     low_ch;
   logic              any_mm;
   logic              inj_ok;
   logic              inj_hit;
   logic              armed_q;
   logic              armed_d;
   logic              edge_q;
   logic [CNT_W-1:0]  cnt_inc;

   dcls_state_e       state_q;
   logic              flag_q;
   logic [NUM_CH-1:0] ch_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [FW-1:0]     first_q;

   assign pipe_in = {bus.main_valid_i, bus.main_data_i};

   el2_dcls_delay_line #(
      .WIDTH (PW),
      .DEPTH (DELAY)
   ) u_dly (
      .clk    (clk),
      .rst    (rst),
      .din_i  (pipe_in),
      .dout_o (pipe_out)
   );

   assign m_data  = pipe_out[DW-1:0];
   assign m_valid = pipe_out[PW-1:DW];
   assign both    = bus.ch_mask_i & m_valid & bus.shadow_valid_i;
   assign inj_ok  = armed_q & ~bus.disable_detection_i
                  & (state_q != DISABLED);

   // Injected flip lives only on the compare path, never on the bus.
   always_comb begin
      s_cmp   = bus.shadow_data_i;
      inj_hit = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (inj_ok && both[k] && !inj_hit) begin
            s_cmp[k*CH_W] = ~s_cmp[k*CH_W];
            inj_hit       = 1'b1;
         end
      end
   end

   always_comb begin
      mm = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         mm[k] = bus.ch_mask_i[k]
               & ((m_valid[k] ^ bus.shadow_valid_i[k])
               | (both[k] & (m_data[k*CH_W +: CH_W]
                             != s_cmp[k*CH_W +: CH_W])));
      end
   end

   always_comb begin
      low_ch = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (mm[k]) low_ch = FW'(k);
      end
   end

   assign any_mm  = |mm;
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      armed_d = armed_q;
      if (!armed_q && bus.err_inj_en_i && !edge_q) armed_d = 1'b1;
      else if (inj_hit)                           armed_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         edge_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         edge_q  <= bus.err_inj_en_i;
         armed_q <= armed_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MONITOR;
         flag_q  <= 1'b0;
         ch_q    <= '0;
         cnt_q   <= '0;
         first_q <= '0;
      end else begin
         unique case (state_q)
            DISABLED: begin
               if (!bus.disable_detection_i) state_q <= MONITOR;
               if (bus.clear_i) begin
                  flag_q  <= 1'b0;
                  ch_q    <= '0;
                  cnt_q   <= '0;
                  first_q <= '0;
               end
            end
            MONITOR: begin
               if (bus.disable_detection_i) begin
                  state_q <= DISABLED;
               end else if (any_mm) begin
                  state_q <= FAULT;
                  flag_q  <= 1'b1;
                  ch_q    <= ch_q | mm;
                  cnt_q   <= cnt_inc;
                  first_q <= low_ch;
               end else if (bus.clear_i) begin
                  flag_q  <= 1'b0;
                  ch_q    <= '0;
                  cnt_q   <= '0;
                  first_q <= '0;
               end
            end
            FAULT: begin
               if (bus.clear_i && any_mm) begin
                  flag_q <= 1'b1;
                  ch_q   <= mm;
                  cnt_q  <= CNT_W'(1);
               end else if (bus.clear_i) begin
                  state_q <= bus.disable_detection_i ? DISABLED : MONITOR;
                  flag_q  <= 1'b0;
                  ch_q    <= '0;
                  cnt_q   <= '0;
                  first_q <= '0;
               end else if (any_mm) begin
                  ch_q  <= ch_q | mm;
                  cnt_q <= cnt_inc;
               end
            end
            default: state_q <= MONITOR;
         endcase
      end
   end

   assign bus.corruption_detected_o = flag_q;
   assign bus.mismatch_ch_o         = ch_q;
   assign bus.mismatch_cnt_o        = cnt_q;
   assign bus.first_ch_o            = first_q;
   assign bus.state_o               = state_q;

endmodule

// File: tb/tb_el2_dcls_comparator.sv
// Directed plus randomized bench for the lockstep comparator with a
// cycle-level reference model.
module tb_el2_dcls_comparator;

   localparam int NCH  = 4;
   localparam int CW   = 32;
   localparam int DLY  = 2;
   localparam int CNW  = 4;
   localparam int CMAX = (1 << CNW) - 1;
   localparam int PW   = NCH * CW + NCH;

   typedef logic [PW-1:0] pkt_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   el2_dcls_comparator_if #(.NUM_CH(NCH), .CH_W(CW), .CNT_W(CNW)) bus ();

   el2_dcls_comparator #(
      .NUM_CH (NCH),
      .CH_W   (CW),
      .DELAY  (DLY),
      .CNT_W  (CNW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [NCH*CW-1:0] md, sd;
   logic [NCH-1:0]    mv, sv, mask;
   logic              dis, inj, clr;

   int n_chk  = 0;
   int n_pass = 0;

   pkt_t g[$];
   pkt_t mq[$];
   int   m_state, m_cnt, m_first;
   bit   m_flag, m_edge, m_armed;
   bit [NCH-1:0] m_ch;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_state = 1; m_cnt = 0; m_first = 0;
      m_flag = 0; m_edge = 0; m_armed = 0; m_ch = '0;
      mq.delete();
      for (int i = 0; i < DLY; i++) mq.push_back('0);
   endtask

   task automatic model_clear();
      m_flag = 0; m_ch = '0; m_cnt = 0; m_first = 0;
   endtask

   task automatic model_step();
      pkt_t old;
      logic [NCH-1:0] dv;
      bit [NCH-1:0] mm;
      logic [CW-1:0] a, b;
      bit ok, used;
      int low;
      mq.push_back({mv, md});
      old  = mq.pop_front();
      dv   = old[NCH*CW +: NCH];
      ok   = m_armed && !dis && m_state != 0;
      used = 0; mm = '0; low = 0;
      for (int k = 0; k < NCH; k++) begin
         a = old[k*CW +: CW];
         b = sd[k*CW +: CW];
         if (mask[k] && dv[k] && sv[k]) begin
            if (ok && !used) begin b[0] = ~b[0]; used = 1; end
            if (a != b) mm[k] = 1;
         end else if (mask[k] && dv[k] != sv[k]) mm[k] = 1;
      end
      for (int k = NCH - 1; k >= 0; k--) if (mm[k]) low = k;
      case (m_state)
         0: begin
            if (!dis) m_state = 1;
            if (clr) model_clear();
         end
         1: begin
            if (dis) m_state = 0;
            else if (mm != 0) begin
               m_state = 2; m_flag = 1; m_ch = mm;
               m_cnt = 1; m_first = low;
            end else if (clr) model_clear();
         end
         default: begin
            if (clr && mm != 0) begin
               m_ch = mm; m_cnt = 1; m_flag = 1;
            end else if (clr) begin
               model_clear();
               m_state = dis ? 0 : 1;
            end else if (mm != 0) begin
               m_ch = m_ch | mm;
               if (m_cnt < CMAX) m_cnt++;
            end
         end
      endcase
      if (used) m_armed = 0;
      else if (inj && !m_edge) m_armed = 1;
      m_edge = inj;
   endtask

   task automatic apply();
      bus.main_data_i         = md;
      bus.main_valid_i        = mv;
      bus.shadow_data_i       = sd;
      bus.shadow_valid_i      = sv;
      bus.ch_mask_i           = mask;
      bus.disable_detection_i = dis;
      bus.err_inj_en_i        = inj;
      bus.clear_i             = clr;
   endtask

   task automatic tick(input string tag);
      apply();
      if (rst) model_reset();
      else model_step();
      @(posedge clk);
      #1;
      chk({tag, ".flag"},  64'(bus.corruption_detected_o), 64'(m_flag));
      chk({tag, ".ch"},    64'(bus.mismatch_ch_o),         64'(m_ch));
      chk({tag, ".cnt"},   64'(bus.mismatch_cnt_o),        64'(m_cnt));
      chk({tag, ".first"}, 64'(bus.first_ch_o),            64'(m_first));
      chk({tag, ".state"}, 64'(bus.state_o),               64'(m_state));
   endtask

   task automatic drive_eq(input logic [NCH*CW-1:0] d,
                           input logic [NCH-1:0] v);
      pkt_t p;
      md = d; mv = v;
      g.push_back({v, d});
      p  = g.pop_front();
      sd = p[NCH*CW-1:0];
      sv = p[NCH*CW +: NCH];
   endtask

   task automatic gen_reset();
      g.delete();
      for (int i = 0; i < DLY; i++) g.push_back('0);
   endtask

   function automatic logic [NCH*CW-1:0] rnd();
      logic [NCH*CW-1:0] r;
      for (int k = 0; k < NCH; k++) r[k*CW +: CW] = $urandom;
      return r;
   endfunction

   logic [NCH*CW-1:0] steady;

   initial begin
      md = '0; sd = '0; mv = '0; sv = '0; mask = 4'b1111;
      dis = 0; inj = 0; clr = 0; rst = 1;
      tick("reset");
      chk("reset.state_c", 64'(bus.state_o), 64'd1);
      chk("reset.cnt_c", 64'(bus.mismatch_cnt_o), 64'd0);
      rst = 0;
      gen_reset();

      for (int i = 0; i < 100; i++) begin
         drive_eq(rnd(), 4'($urandom));
         tick("s1");
      end
      chk("s1.flag_c", 64'(bus.corruption_detected_o), 64'd0);
      chk("s1.cnt_c", 64'(bus.mismatch_cnt_o), 64'd0);
      chk("s1.state_c", 64'(bus.state_o), 64'd1);

      steady = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0};
      for (int i = 0; i < 2; i++) begin
         drive_eq(steady, 4'b1111);
         tick("s2.pre");
      end
      drive_eq(steady, 4'b1111);
      sd[2*CW +: CW] = 32'hDEAD_BEEE;
      tick("s2");
      chk("s2.flag_c", 64'(bus.corruption_detected_o), 64'd1);
      chk("s2.ch_c", 64'(bus.mismatch_ch_o), 64'b0100);
      chk("s2.first_c", 64'(bus.first_ch_o), 64'd2);
      chk("s2.cnt_c", 64'(bus.mismatch_cnt_o), 64'd1);
      chk("s2.state_c", 64'(bus.state_o), 64'd2);
      clr = 1;
      drive_eq(steady, 4'b1111);
      tick("s2.clr");
      clr = 0;
      chk("s2.clr_c", 64'(bus.state_o), 64'd1);

      mask = 4'b1110;
      for (int i = 0; i < 2; i++) begin
         drive_eq(rnd(), 4'b0011);
         tick("s3.pre");
      end
      inj = 1;
      drive_eq(rnd(), 4'b0011);
      tick("s3.arm");
      drive_eq(rnd(), 4'b0011);
      tick("s3.hit");
      chk("s3.ch_c", 64'(bus.mismatch_ch_o), 64'b0010);
      chk("s3.first_c", 64'(bus.first_ch_o), 64'd1);
      clr = 1;
      drive_eq(rnd(), 4'b0011);
      tick("s3.clr");
      clr = 0;
      for (int i = 0; i < 5; i++) begin
         drive_eq(rnd(), 4'b0011);
         tick("s3.hold");
      end
      chk("s3.once_c", 64'(bus.mismatch_cnt_o), 64'd0);
      chk("s3.state_c", 64'(bus.state_o), 64'd1);
      inj = 0;

      for (int i = 0; i < 20; i++) begin
         drive_eq(rnd(), 4'b0011);
         sv = sv ^ 4'b1000;
         tick("s4");
      end
      chk("s4.sat_c", 64'(bus.mismatch_cnt_o), 64'd15);
      chk("s4.state_c", 64'(bus.state_o), 64'd2);
      clr = 1; mask = 4'b1111;
      drive_eq(rnd(), 4'b1111);
      tick("s4.clr");
      clr = 0;

      dis = 1;
      drive_eq(rnd(), 4'b1111);
      tick("s5.dis");
      chk("s5.dis_c", 64'(bus.state_o), 64'd0);
      for (int i = 0; i < 3; i++) begin
         drive_eq(rnd(), 4'b1111);
         sd[0] = ~sd[0];
         tick("s5.dmm");
      end
      chk("s5.dflag_c", 64'(bus.corruption_detected_o), 64'd0);
      chk("s5.dcnt_c", 64'(bus.mismatch_cnt_o), 64'd0);
      dis = 0;
      drive_eq(rnd(), 4'b1111);
      tick("s5.en");
      drive_eq(rnd(), 4'b1111);
      sd[CW+5] = ~sd[CW+5];
      tick("s5.mm");
      dis = 1;
      for (int i = 0; i < 2; i++) begin
         drive_eq(rnd(), 4'b1111);
         tick("s5.fdis");
      end
      chk("s5.stay_c", 64'(bus.state_o), 64'd2);
      dis = 0; clr = 1;
      drive_eq(rnd(), 4'b1111);
      sd[3*CW] = ~sd[3*CW];
      tick("s5.clrmm");
      chk("s5.cnt1_c", 64'(bus.mismatch_cnt_o), 64'd1);
      chk("s5.fault_c", 64'(bus.state_o), 64'd2);
      chk("s5.ch_c", 64'(bus.mismatch_ch_o), 64'b1000);
      drive_eq(rnd(), 4'b1111);
      tick("s5.clr");
      clr = 0;

      drive_eq(rnd(), 4'b1111);
      sd[2] = ~sd[2];
      tick("s6.mm");
      mask = 4'b0000; inj = 1;
      for (int i = 0; i < 2; i++) begin
         drive_eq(rnd(), 4'b1111);
         tick("s6.arm");
      end
      rst = 1; inj = 0;
      tick("s6.rst");
      chk("s6.flag_c", 64'(bus.corruption_detected_o), 64'd0);
      chk("s6.ch_c", 64'(bus.mismatch_ch_o), 64'd0);
      chk("s6.first_c", 64'(bus.first_ch_o), 64'd0);
      chk("s6.state_c", 64'(bus.state_o), 64'd1);
      rst = 0; mask = 4'b1111;
      gen_reset();
      for (int i = 0; i < 20; i++) begin
         drive_eq(rnd(), 4'b1111);
         tick("s6.eq");
      end
      chk("s6.nofault_c", 64'(bus.corruption_detected_o), 64'd0);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) dis = ~dis;
         if ($urandom_range(0, 5) == 0) inj = ~inj;
         if ($urandom_range(0, 9) == 0) mask = 4'($urandom);
         clr = ($urandom_range(0, 9) == 0);
         rst = ($urandom_range(0, 99) == 0);
         drive_eq(rnd(), 4'($urandom));
         if ($urandom_range(0, 7) == 0)
            sd[$urandom_range(0, NCH*CW-1)] ^= 1'b1;
         if ($urandom_range(0, 15) == 0)
            sv[$urandom_range(0, NCH-1)] ^= 1'b1;
         tick("rand");
         if (rst) gen_reset();
      end
      rst = 0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
